// File: rtl/train_dispatch_checker.sv
// Train-dispatch feasibility checker: loads a target car order, then replays
// arrivals through a bounded stack or queue siding and reports the verdict.
module train_dispatch_checker #(
  parameter int MAX_CARS = 15,
  parameter int DEPTH    = 8,
  parameter int DW       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         mode,
  input  logic [DW-1:0]                data,
  output logic                         out_valid,
  output logic                         result,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   peak
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [DW-1:0]   n_q;
  logic [DW-1:0]   k_q;
  logic [DW:0]     c_q;
  logic            mode_q;
  logic            bad_q;
  logic [PW-1:0]   occ_q;
  logic [PW-1:0]   peak_q;
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [MAX_CARS:0] used_q;
  logic [DW-1:0]   order_q [MAX_CARS];
  logic [DW-1:0]   sid_q   [DEPTH];

  logic [DW-1:0]   tgt;
  logic [DW-1:0]   front;
  logic            hdr_bad, beat_bad, last_beat;
  logic            act_pop, act_pass, act_push;
  logic            done_ok, done_err;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] p);
    return (p == '0) ? AW'(DEPTH-1) : p - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Both siding modes share one circular buffer: the stack top sits just below tail.
  always_comb begin
    state_nx  = state;
    hdr_bad   = 1'b0;
    beat_bad  = 1'b0;
    last_beat = 1'b0;
    act_pop   = 1'b0;
    act_pass  = 1'b0;
    act_push  = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    tgt       = (int'(k_q) < MAX_CARS) ? order_q[k_q] : '0;
    front     = mode_q ? sid_q[head_q] : sid_q[wrap_dec(tail_q)];
    case (state)
      IDLE: begin
        if (in_valid) begin
          hdr_bad  = (data == '0) || ({1'b0, data} > (DW+1)'(MAX_CARS));
          state_nx = hdr_bad ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        beat_bad  = (data == '0) || (data > n_q) || used_q[data];
        last_beat = (k_q == n_q - 1'b1);
        if (!in_valid) begin
          state_nx = DONE;
          done_err = 1'b1;
        end else if (last_beat) begin
          if (bad_q || beat_bad) begin
            state_nx = DONE;
            done_err = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end
      end
      DRAIN: begin
        if (!in_valid) begin
          state_nx = DONE;
          done_err = 1'b1;
        end
      end
      RUN: begin
        if (occ_q != '0 && front == tgt)                        act_pop  = 1'b1;
        else if (c_q == {1'b0, tgt})                            act_pass = 1'b1;
        else if (c_q < {1'b0, tgt} && occ_q != PW'(DEPTH))     act_push = 1'b1;
        else                                                    state_nx = DONE;
        if ((act_pop || act_pass) && (k_q + 1'b1 == n_q)) begin
          state_nx = DONE;
          done_ok  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      mode_q    <= 1'b0;
      bad_q     <= 1'b0;
      k_q       <= '0;
      c_q       <= '0;
      occ_q     <= '0;
      peak_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      used_q    <= '0;
      out_valid <= 1'b0;
      result    <= 1'b0;
      err       <= 1'b0;
      peak      <= '0;
    end else begin
      out_valid <= 1'b0;
      result    <= 1'b0;
      err       <= 1'b0;
      peak      <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_q    <= data;
            mode_q <= mode;
            bad_q  <= hdr_bad;
            k_q    <= '0;
            c_q    <= (DW+1)'(1);
            occ_q  <= '0;
            peak_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            used_q <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            used_q[data] <= 1'b1;
            if (beat_bad) bad_q <= 1'b1;
            k_q <= last_beat ? '0 : k_q + 1'b1;
          end
        end
        RUN: begin
          if (act_pop) begin
            occ_q <= occ_q - 1'b1;
            k_q   <= k_q + 1'b1;
            if (mode_q) head_q <= wrap_inc(head_q);
            else        tail_q <= wrap_dec(tail_q);
          end
          if (act_pass) begin
            c_q <= c_q + 1'b1;
            k_q <= k_q + 1'b1;
          end
          if (act_push) begin
            c_q    <= c_q + 1'b1;
            occ_q  <= occ_q + 1'b1;
            tail_q <= wrap_inc(tail_q);
            if (occ_q + 1'b1 > peak_q) peak_q <= occ_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (state != DONE && state_nx == DONE) begin
        out_valid <= 1'b1;
        err       <= done_err;
        result    <= done_ok;
        peak      <= done_err ? '0 : peak_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && int'(k_q) < MAX_CARS) order_q[k_q] <= data;
    if (state == RUN && act_push) sid_q[tail_q] <= c_q[DW-1:0];
  end

endmodule

// File: tb/tb_train_dispatch_checker.sv
// Bench for train_dispatch_checker: three siding depths share one stimulus
// stream and are checked every cycle against a queue-based feasibility model.
module tb_train_dispatch_checker;

  localparam int MC = 15;
  localparam int DW = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst, in_valid, mode;
  logic [DW-1:0] data;

  logic ov8, res8, err8; logic [3:0] pk8;
  logic ov2, res2, err2; logic [1:0] pk2;
  logic ov3, res3, err3; logic [1:0] pk3;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  bit pend  [NI];
  int ecyc  [NI];
  bit eres  [NI];
  bit eerr  [NI];
  int epeak [NI];

  train_dispatch_checker #(.MAX_CARS(MC), .DEPTH(8), .DW(DW)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .data(data),
    .out_valid(ov8), .result(res8), .err(err8), .peak(pk8));
  train_dispatch_checker #(.MAX_CARS(MC), .DEPTH(2), .DW(DW)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .data(data),
    .out_valid(ov2), .result(res2), .err(err2), .peak(pk2));
  train_dispatch_checker #(.MAX_CARS(MC), .DEPTH(3), .DW(DW)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .data(data),
    .out_valid(ov3), .result(res3), .err(err3), .peak(pk3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dep_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 3;
  endfunction

  // Replays arrivals against a plain SV queue used as the siding.
  function automatic void model(input bit md, input int dep, input int n, input int ord[$],
                                output bit res, output int pk, output int r);
    int sid[$];
    int c, k, front;
    c = 1; k = 0; r = 0; res = 1'b0; pk = 0;
    for (int it = 0; it < 4 * MC; it++) begin
      r++;
      front = -1;
      if (sid.size() > 0) front = md ? sid[0] : sid[sid.size()-1];
      if (sid.size() > 0 && front == ord[k]) begin
        if (md) void'(sid.pop_front()); else void'(sid.pop_back());
        k++;
      end else if (c == ord[k]) begin
        c++; k++;
      end else if (c < ord[k] && sid.size() < dep) begin
        sid.push_back(c);
        c++;
        if (sid.size() > pk) pk = sid.size();
      end else begin
        return;
      end
      if (k == n) begin
        res = 1'b1;
        return;
      end
    end
  endfunction

  function automatic bit malformed(input int n, input int ord[$]);
    bit seen [32];
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (ord[b] == 0 || ord[b] > n || seen[ord[b]]) return 1'b1;
      seen[ord[b]] = 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic pin(input string nm, input bit md, input int dep, input int n, input int q[$],
                     input bit xres, input int xpk, input int xr);
    bit r; int p, rr;
    model(md, dep, n, q, r, p, rr);
    tests++;
    if (r != xres || p != xpk || rr != xr) begin
      fails++;
      $display("FAIL pin %s: model res=%0b peak=%0d R=%0d, expected res=%0b peak=%0d R=%0d",
               nm, r, p, rr, xres, xpk, xr);
    end
  endtask

  // Compare process: pins the model, then checks every DUT on every cycle.
  initial begin
    int q[$];
    bit want, a_ov, a_res, a_err;
    int a_pk;
    q = '{5, 4, 3, 2, 1};          pin("stack54321_d8", 1'b0, 8, 5, q, 1'b1, 4, 9);
    q = '{3, 1, 2};                pin("stack312_d8",   1'b0, 8, 3, q, 1'b0, 2, 4);
    pin("queue312_d8", 1'b1, 8, 3, q, 1'b1, 2, 5);
    q = '{4, 3, 2, 1};             pin("stack4321_d2",  1'b0, 2, 4, q, 1'b0, 2, 3);
    pin("stack4321_d3", 1'b0, 3, 4, q, 1'b1, 3, 7);
    q = '{2, 1, 4, 3, 6, 5};       pin("queue_wrap_d2", 1'b1, 2, 6, q, 1'b1, 1, 9);
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        case (i)
          0:       begin a_ov = ov8; a_res = res8; a_err = err8; a_pk = int'(pk8); end
          1:       begin a_ov = ov2; a_res = res2; a_err = err2; a_pk = int'(pk2); end
          default: begin a_ov = ov3; a_res = res3; a_err = err3; a_pk = int'(pk3); end
        endcase
        want = pend[i] && (cyc == ecyc[i]);
        tests++;
        if (want) begin
          if (a_ov !== 1'b1 || a_res !== eres[i] || a_err !== eerr[i] || a_pk != epeak[i]) begin
            fails++;
            $display("FAIL verdict d%0d cyc %0d: got ov=%0b res=%0b err=%0b peak=%0d, want ov=1 res=%0b err=%0b peak=%0d",
                     dep_of(i), cyc, a_ov, a_res, a_err, a_pk, eres[i], eerr[i], epeak[i]);
          end
        end else if (a_ov !== 1'b0 || a_res !== 1'b0 || a_err !== 1'b0 || a_pk != 0) begin
          fails++;
          $display("FAIL quiet d%0d cyc %0d: got ov=%0b res=%0b err=%0b peak=%0d, want all 0",
                   dep_of(i), cyc, a_ov, a_res, a_err, a_pk);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of the header cycle; returns in the first idle-input cycle.
  task automatic start_txn(input bit md, input int n, input int q[$], input int nb);
    int c0, rr, pk;
    bit r, hb;
    c0 = cyc;
    in_valid = 1'b1; mode = md; data = DW'(n);
    for (int b = 0; b < nb; b++) begin
      step();
      data = DW'(q[b]);
      mode = ~md;
    end
    step();
    in_valid = 1'b0; data = '0;
    hb = (n == 0 || n > MC);
    for (int i = 0; i < NI; i++) begin
      if (hb || nb < n) begin
        ecyc[i] = c0 + nb + 2; eres[i] = 1'b0; eerr[i] = 1'b1; epeak[i] = 0;
      end else if (malformed(n, q)) begin
        ecyc[i] = c0 + n + 1;  eres[i] = 1'b0; eerr[i] = 1'b1; epeak[i] = 0;
      end else begin
        model(md, dep_of(i), n, q, r, pk, rr);
        ecyc[i] = c0 + n + rr + 1; eres[i] = r; eerr[i] = 1'b0; epeak[i] = pk;
      end
      pend[i] = 1'b1;
    end
  endtask

  task automatic wait_done();
    int last;
    last = 0;
    for (int i = 0; i < NI; i++) if (ecyc[i] > last) last = ecyc[i];
    while (cyc < last) step();
  endtask

  task automatic txn(input bit md, input int n, input int q[$], input int nb);
    step();
    start_txn(md, n, q, nb);
    wait_done();
  endtask

  initial begin
    int q[$];
    for (int i = 0; i < NI; i++) begin pend[i] = 1'b0; ecyc[i] = 0; end
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    q = '{5, 4, 3, 2, 1};                          txn(1'b0, 5, q, 5);
    q = '{3, 1, 2};                                txn(1'b0, 3, q, 3);
    txn(1'b1, 3, q, 3);
    q = '{4, 3, 2, 1};                             txn(1'b0, 4, q, 4);
    txn(1'b1, 4, q, 4);
    q = '{1, 1, 2};                                txn(1'b0, 3, q, 3);
    q = '{1, 4, 2};                                txn(1'b1, 3, q, 3);
    q = '{1, 2};                                   txn(1'b0, 0, q, 2);
    q = '{1, 2, 3, 4};                             txn(1'b0, 4, q, 2);
    q = '{2, 1, 4, 3, 6, 5};                       txn(1'b1, 6, q, 6);
    q = '{3, 1, 2, 6, 4, 5, 8, 7};                 txn(1'b1, 8, q, 8);
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    txn(1'b0, 15, q, 15);
    q = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    txn(1'b0, 15, q, 15);
    // Abort a 10-car run with a one-cycle reset, then start straight away.
    q = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    step();
    start_txn(1'b0, 10, q, 10);
    step();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) pend[i] = 1'b0;
    step();
    rst = 1'b0;
    q = '{1};
    start_txn(1'b0, 1, q, 1);
    wait_done();
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
